// File: rtl/hdec_thermo_encoder.sv
// Pipelined thermometer-to-binary encoder: K-stage binary search with a global stall.
// Define HDEC_THERMO_ENCODER_CHECK_EN to flag input words that are not legal thermometer codes.
module hdec_thermo_encoder #(
    parameter int K = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2**K-1:0] in_therm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K:0]     out_count,
    output logic           out_err
);

    localparam int W  = 2 ** K;
    // Only stages that feed a later search step need their own copy of the word.
    localparam int NW = (K > 1) ? K - 1 : 1;

    logic             advance;
    logic [K-1:0]     valid_q;
    logic [K-1:0]     full_q;
    logic [W-1:0]     word_q [NW];
    logic [K-1:0]     r_q    [K];
    logic [K-1:0]     r_next [K];
    logic [K-1:0]     step;
    logic [K-1:0]     probe;

    assign advance  = ~valid_q[K-1] | out_ready;
    assign in_ready = advance;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        step      = '0;
        probe     = '0;
        r_next[0] = in_therm[W/2-1] ? K'(W / 2) : '0;
        for (int s = 1; s < K; s++) begin
            step      = K'(1) << (K - 1 - s);
            probe     = r_q[s-1] + step - K'(1);
            r_next[s] = word_q[s-1][probe] ? r_q[s-1] + step : r_q[s-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the array
    // registers are cleared in reset too, so no X data ever reaches out_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            full_q  <= '0;
            for (int s = 0; s < NW; s++) word_q[s] <= '0;
            for (int s = 0; s < K; s++)  r_q[s]    <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            full_q[0]  <= &in_therm;
            word_q[0]  <= in_therm;
            r_q[0]     <= r_next[0];
            for (int s = 1; s < K; s++) begin
                valid_q[s] <= valid_q[s-1];
                full_q[s]  <= full_q[s-1];
                r_q[s]     <= r_next[s];
            end
            for (int s = 1; s < K - 1; s++) word_q[s] <= word_q[s-1];
        end
    end

    assign out_valid = valid_q[K-1];
    assign out_count = full_q[K-1] ? (K+1)'(W) : {1'b0, r_q[K-1]};

`ifdef HDEC_THERMO_ENCODER_CHECK_EN
    logic [K-1:0] err_q;
    logic [W:0]   ext_word;
    logic         err_in;

    // Extended by one bit so that all-ones + 1 carries out instead of wrapping.
    assign ext_word = {1'b0, in_therm};
    assign err_in   = |((ext_word + (W+1)'(1)) & ext_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (advance) begin
            err_q[0] <= err_in;
            for (int s = 1; s < K; s++) err_q[s] <= err_q[s-1];
        end
    end

    assign out_err = err_q[K-1];
`else
    assign out_err = 1'b0;
`endif

endmodule
